game_state_ctl: RTL and testbench

- Generates the `g_state` value consumed by the top-level display selector: START, LEVEL_1 or FINISH.
- Takes mouse, player position and the display frame timing as inputs.
- Requests from clicks and player position are latched, then committed only at a frame boundary (vsync rising edge), so the display never switches pipelines mid-frame.
- Also provides a level timer and a one-cycle state-change pulse for the drawing logic.

---
 rtl/game_state_ctl.sv | 169 ++++++++++++++++
 tb/tb_game_state_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctl.sv
// Game state controller. Mouse clicks and player position latch a request,
// which is committed only on a vsync rising edge.
package game_state_pkg;
    typedef enum logic [1:0] {
        START   = 2'd0,
        LEVEL_1 = 2'd1,
        FINISH  = 2'd2
    } g_state;
endpackage

module game_state_ctl
    import game_state_pkg::*;
#(
    parameter int unsigned BTN_X0         = 350,
    parameter int unsigned BTN_X1         = 450,
    parameter int unsigned BTN_Y0         = 280,
    parameter int unsigned BTN_Y1         = 320,
    parameter int unsigned EXIT_X0        = 740,
    parameter int unsigned EXIT_Y0        = 500,
    parameter int unsigned EXIT_FRAMES    = 30,
    parameter int unsigned FINISH_FRAMES  = 300,
    parameter int unsigned FRAMES_PER_SEC = 60
) (
    input  logic        clk_40,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        m_left,
    input  logic [11:0] xpos_mouse,
    input  logic [11:0] ypos_mouse,
    input  logic [11:0] xpos_player,
    input  logic [11:0] ypos_player,
    output g_state      game_state,
    output logic        state_changed,
    output logic [7:0]  level_time_s,
    output logic        pending
);

    localparam int unsigned FIN_W = $clog2(FINISH_FRAMES + 1);
    localparam int unsigned FRM_W = $clog2(FRAMES_PER_SEC + 1);

    logic             r_m_left_d;
    logic             r_vsync_d;
    g_state           r_state;
    g_state           r_target;
    logic             r_pending;
    logic             r_state_changed;
    logic [7:0]       r_dwell_cnt;
    logic [FIN_W-1:0] r_fin_cnt;
    logic [FRM_W-1:0] r_lvl_frm;
    logic [7:0]       r_lvl_sec;

    g_state           w_state_next;
    g_state           w_target_next;
    g_state           w_req_target;
    logic             w_pending_next;
    logic             w_req;
    logic             w_commit;
    logic             w_illegal;
    logic             w_click;
    logic             w_frame_tick;
    logic             w_in_button;
    logic             w_in_exit;

    assign w_click      = m_left & ~r_m_left_d;
    assign w_frame_tick = vsync & ~r_vsync_d;
    assign w_in_button  = (xpos_mouse >= 12'(BTN_X0)) && (xpos_mouse <= 12'(BTN_X1)) &&
                          (ypos_mouse >= 12'(BTN_Y0)) && (ypos_mouse <= 12'(BTN_Y1));
    assign w_in_exit    = (xpos_player >= 12'(EXIT_X0)) && (ypos_player >= 12'(EXIT_Y0));

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_m_left_d <= 1'b0;
            r_vsync_d  <= 1'b0;
        end else begin
            r_m_left_d <= m_left;
            r_vsync_d  <= vsync;
        end
    end

    // A request latched on a tick cycle only sees r_pending at the following tick.
    always_comb begin
        w_req          = 1'b0;
        w_req_target   = START;
        w_illegal      = 1'b0;
        w_commit       = 1'b0;
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_pending_next = r_pending;
        case (r_state)
            START: begin
                w_req        = w_click && w_in_button;
                w_req_target = LEVEL_1;
            end
            LEVEL_1: begin
                w_req        = (r_dwell_cnt >= 8'(EXIT_FRAMES));
                w_req_target = FINISH;
            end
            FINISH: begin
                w_req        = w_click || (r_fin_cnt >= FIN_W'(FINISH_FRAMES));
                w_req_target = START;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_frame_tick && (r_pending || w_illegal)) begin
            w_commit       = 1'b1;
            w_state_next   = w_illegal ? START : r_target;
            w_pending_next = 1'b0;
        end else if (!r_pending && w_req) begin
            w_pending_next = 1'b1;
            w_target_next  = w_req_target;
        end
    end

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= START;
            r_target        <= START;
            r_pending       <= 1'b0;
            r_state_changed <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_target        <= w_target_next;
            r_pending       <= w_pending_next;
            r_state_changed <= w_commit;
        end
    end

    // The level timer survives the move into FINISH so the result can be shown.
    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
            r_fin_cnt   <= '0;
            r_lvl_frm   <= '0;
            r_lvl_sec   <= '0;
        end else if (w_commit) begin
            r_dwell_cnt <= '0;
            r_fin_cnt   <= '0;
            if (w_state_next != FINISH) begin
                r_lvl_frm <= '0;
                r_lvl_sec <= '0;
            end
        end else if (w_frame_tick) begin
            if (r_state == LEVEL_1) begin
                if (!w_in_exit) begin
                    r_dwell_cnt <= '0;
                end else if (r_dwell_cnt < 8'(EXIT_FRAMES)) begin
                    r_dwell_cnt <= r_dwell_cnt + 8'd1;
                end
                if (r_lvl_frm == FRM_W'(FRAMES_PER_SEC - 1)) begin
                    r_lvl_frm <= '0;
                    if (r_lvl_sec != 8'hFF) begin
                        r_lvl_sec <= r_lvl_sec + 8'd1;
                    end
                end else begin
                    r_lvl_frm <= r_lvl_frm + FRM_W'(1);
                end
            end
            if ((r_state == FINISH) && (r_fin_cnt < FIN_W'(FINISH_FRAMES))) begin
                r_fin_cnt <= r_fin_cnt + FIN_W'(1);
            end
        end
    end

    assign game_state    = r_state;
    assign state_changed = r_state_changed;
    assign level_time_s  = r_lvl_sec;
    assign pending       = r_pending;

endmodule

// File: tb/tb_game_state_ctl.sv
// Bench for game_state_ctl: a button hit-test table, hand-written frame
// sequences, and a scoreboard of expected commits checked on state_changed.
module tb_game_state_ctl;
    import game_state_pkg::*;

    logic        clk_40 = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        m_left;
    logic [11:0] xpos_mouse;
    logic [11:0] ypos_mouse;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    g_state      game_state;
    logic        state_changed;
    logic [7:0]  level_time_s;
    logic        pending;

    typedef struct {
        g_state     state;
        logic [7:0] levelTime;
    } expect_t;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        hit;
    } btn_vec_t;

    expect_t  sbQueue[$];
    btn_vec_t btnTable[8];
    int       errors = 0;
    int       checks = 0;

    always #5 clk_40 = ~clk_40;

    game_state_ctl dut (
        .clk_40       (clk_40),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .m_left       (m_left),
        .xpos_mouse   (xpos_mouse),
        .ypos_mouse   (ypos_mouse),
        .xpos_player  (xpos_player),
        .ypos_player  (ypos_player),
        .game_state   (game_state),
        .state_changed(state_changed),
        .level_time_s (level_time_s),
        .pending      (pending)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vs, input logic ml);
        vsync  = vs;
        m_left = ml;
        @(posedge clk_40);
        #1;
    endtask

    task automatic runFrames(input int n, input int len);
        for (int f = 0; f < n; f++) begin
            applyStimulus(1'b1, 1'b0);
            for (int c = 1; c < len; c++) applyStimulus(1'b0, 1'b0);
        end
    endtask

    task automatic pushExpect(input g_state s, input logic [7:0] lt);
        expect_t e;
        e.state     = s;
        e.levelTime = lt;
        sbQueue.push_back(e);
    endtask

    task automatic commitFrame(input string name, input g_state expState, input int len);
        applyStimulus(1'b1, 1'b0);
        checkOutput({name, ".state"}, game_state, expState);
        checkOutput({name, ".changed"}, state_changed, 1);
        checkOutput({name, ".pending"}, pending, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput({name, ".pulse_end"}, state_changed, 0);
        for (int c = 2; c < len; c++) applyStimulus(1'b0, 1'b0);
    endtask

    // Every committed transition must match the oldest outstanding expectation.
    always @(negedge clk_40) begin
        if (state_changed === 1'b1) begin
            expect_t e;
            checks++;
            if (sbQueue.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_commit: state=%0d, no commit expected", game_state);
            end else begin
                e = sbQueue.pop_front();
                if (game_state !== e.state || level_time_s !== e.levelTime) begin
                    errors++;
                    $display("[TB] FAIL sb_commit: state=%0d lt=%0d, expected state=%0d lt=%0d",
                             game_state, level_time_s, e.state, e.levelTime);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        vsync       = 1'b0;
        m_left      = 1'b0;
        xpos_mouse  = '0;
        ypos_mouse  = '0;
        xpos_player = '0;
        ypos_player = '0;
        btnTable[0] = '{12'd400, 12'd300, 1'b1};
        btnTable[1] = '{12'd350, 12'd280, 1'b1};
        btnTable[2] = '{12'd450, 12'd320, 1'b1};
        btnTable[3] = '{12'd349, 12'd300, 1'b0};
        btnTable[4] = '{12'd451, 12'd300, 1'b0};
        btnTable[5] = '{12'd400, 12'd279, 1'b0};
        btnTable[6] = '{12'd400, 12'd321, 1'b0};
        btnTable[7] = '{12'd350, 12'd320, 1'b1};

        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("reset.state", game_state, START);
        checkOutput("reset.lt", level_time_s, 0);
        checkOutput("reset.pending", pending, 0);
        checkOutput("reset.changed", state_changed, 0);
        rst_n = 1'b1;
        runFrames(3, 4);
        checkOutput("post_reset.state", game_state, START);

        for (int i = 0; i < 8; i++) begin
            xpos_mouse = btnTable[i].x;
            ypos_mouse = btnTable[i].y;
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("btn_tbl[%0d].pending", i), pending, btnTable[i].hit);
            applyStimulus(1'b0, 1'b0);
            if (btnTable[i].hit) begin
                rst_n = 1'b0;
                #1;
                checkOutput($sformatf("btn_tbl[%0d].rst_pending", i), pending, 0);
                repeat (2) applyStimulus(1'b0, 1'b0);
                rst_n = 1'b1;
            end
            runFrames(2, 4);
            checkOutput($sformatf("btn_tbl[%0d].state", i), game_state, START);
        end

        // Button held for several cycles must raise exactly one request.
        xpos_mouse = 12'd400;
        ypos_mouse = 12'd300;
        applyStimulus(1'b0, 1'b1);
        checkOutput("start_click.pending", pending, 1);
        checkOutput("start_click.state", game_state, START);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("start_click.hold_state", game_state, START);
        pushExpect(LEVEL_1, 8'd0);
        commitFrame("start_commit", LEVEL_1, 4);

        xpos_mouse = 12'd451;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("l1_click.pending", pending, 0);

        runFrames(150, 4);
        checkOutput("timer150.lt", level_time_s, 2);
        checkOutput("timer150.pending", pending, 0);

        xpos_player = 12'd760;
        ypos_player = 12'd520;
        runFrames(29, 4);
        xpos_player = 12'd700;
        runFrames(1, 4);
        checkOutput("dwell_break.pending", pending, 0);
        xpos_player = 12'd760;
        runFrames(29, 4);
        checkOutput("dwell29.pending", pending, 0);
        runFrames(1, 4);
        checkOutput("dwell30.pending", pending, 1);
        checkOutput("dwell30.state", game_state, LEVEL_1);
        checkOutput("dwell30.lt", level_time_s, 3);
        pushExpect(FINISH, 8'd3);
        commitFrame("finish_commit", FINISH, 4);
        xpos_player = '0;
        ypos_player = '0;

        runFrames(299, 4);
        checkOutput("fin299.pending", pending, 0);
        checkOutput("fin299.state", game_state, FINISH);
        runFrames(1, 4);
        checkOutput("fin300.pending", pending, 1);
        checkOutput("fin300.lt_hold", level_time_s, 3);
        pushExpect(START, 8'd0);
        commitFrame("auto_return", START, 4);
        checkOutput("auto_return.lt", level_time_s, 0);

        xpos_mouse = 12'd400;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart.pending", pending, 1);
        pushExpect(LEVEL_1, 8'd0);
        commitFrame("restart_commit", LEVEL_1, 4);
        runFrames(16000, 2);
        checkOutput("timer_sat.lt", level_time_s, 255);
        xpos_player = 12'd760;
        ypos_player = 12'd520;
        runFrames(30, 4);
        checkOutput("sat_exit.pending", pending, 1);
        pushExpect(FINISH, 8'd255);
        commitFrame("sat_finish", FINISH, 4);
        xpos_player = '0;
        ypos_player = '0;

        runFrames(10, 4);
        checkOutput("fin10.pending", pending, 0);
        xpos_mouse = 12'd10;
        ypos_mouse = 12'd10;
        applyStimulus(1'b0, 1'b1);
        checkOutput("fin_click.pending", pending, 1);
        applyStimulus(1'b0, 1'b0);
        pushExpect(START, 8'd0);
        commitFrame("click_return", START, 4);

        // Click landing on the same edge as a frame tick waits for the next tick.
        xpos_mouse = 12'd400;
        ypos_mouse = 12'd300;
        applyStimulus(1'b1, 1'b1);
        checkOutput("same_tick.pending", pending, 1);
        checkOutput("same_tick.state", game_state, START);
        checkOutput("same_tick.changed", state_changed, 0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        pushExpect(LEVEL_1, 8'd0);
        commitFrame("same_tick_commit", LEVEL_1, 4);

        xpos_player = 12'd760;
        ypos_player = 12'd520;
        runFrames(30, 4);
        checkOutput("pre_rst.pending", pending, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst.state", game_state, START);
        checkOutput("async_rst.pending", pending, 0);
        checkOutput("async_rst.changed", state_changed, 0);
        repeat (5) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        xpos_player = '0;
        ypos_player = '0;
        runFrames(3, 4);
        checkOutput("after_rst.state", game_state, START);
        checkOutput("after_rst.pending", pending, 0);

        checkOutput("sb_leftover", sbQueue.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
